// File: rtl/flop_sram_pkg.sv
// Shared definitions for the flop-based 1R1W memory model: address-width
// helper and the value Q takes on reset or while shut down.
package flop_sram_pkg;

    // Value of every Q bit after reset and while the macro is shut down.
    localparam logic Q_BLOCK_BIT = 1'b0;

    // Address width for a given depth, never less than one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/flop_sram_word.sv
// One storage word of the flop SRAM: a WIDTH-bit register where each bit is
// loaded from d only when its bit_we is 1, otherwise it keeps its value.
module flop_sram_word
    import flop_sram_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] bit_we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Merge new data into the stored word bit by bit.
    always_comb begin
        data_d = (data_q & ~bit_we) | (d & bit_we);
    end

    // Storage register.
    // NOTE: the array is deliberately not reset; real SRAM contents are
    // undefined after reset and resetting every word would cost a reset net per flop.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps all flops updating from pre-edge values.
        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/flop_sram_1r1w_1clk.sv
// Flop-based 1-read/1-write memory on a single clock, active-low strobes,
// registered read data (1-cycle latency), read-before-write on collision.
// Optional macro FLOP_SRAM_CHECK_EN adds simulation-only immediate assertions.
module flop_sram_1r1w_1clk
    import flop_sram_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 8,
    parameter  int WITH_MASK = 0,
    parameter  int WITH_SD   = 0,
    parameter  int WITH_SLP  = 0,
    localparam int AW        = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    AA,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] BWEB,
    input  logic             WEB,
    input  logic [AW-1:0]    AB,
    input  logic             REB,
    output logic [WIDTH-1:0] Q,
    input  logic             SD,
    input  logic             SLP
);

    localparam logic [WIDTH-1:0] Q_ZERO = {WIDTH{Q_BLOCK_BIT}};

    logic             sd_act;
    logic             slp_act;
    logic             wr_go;
    logic [WIDTH-1:0] bit_we;
    logic [WIDTH-1:0] word_we [DEPTH];
    logic [WIDTH-1:0] words   [DEPTH];
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Power-state qualifiers; disabled features are tied off by parameter.
    assign sd_act  = (WITH_SD != 0) && SD;
    assign slp_act = (WITH_SLP != 0) && SLP;

    // A write is aborted while blocked or while reset is asserted.
    assign wr_go  = !WEB && !sd_act && !slp_act && !rst;
    assign bit_we = (WITH_MASK != 0) ? ~BWEB : {WIDTH{1'b1}};

    // Storage: out-of-range AA matches no word, so such a write is dropped.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign word_we[i] = (wr_go && (AA == AW'(i))) ? bit_we : '0;

        flop_sram_word #(.WIDTH(WIDTH)) u_word (
            .clk    (clk),
            .bit_we (word_we[i]),
            .d      (D),
            .q      (words[i])
        );
    end

    // Read mux; an out-of-range AB selects zero.
    always_comb begin
        // NOTE: default assigned first so no path leaves rd_data unassigned (no latch).
        rd_data = Q_ZERO;
        for (int i = 0; i < DEPTH; i++) begin
            if (AB == AW'(i)) begin
                rd_data = words[i];
            end
        end
    end

    // Next Q: shutdown clears, sleep holds, an enabled read loads the old word.
    always_comb begin
        q_d = q_q;
        if (sd_act) begin
            q_d = Q_ZERO;
        end else if (slp_act) begin
            q_d = q_q;
        end else if (!REB) begin
            q_d = rd_data;
        end
    end

    // Output register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= Q_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

`ifdef FLOP_SRAM_CHECK_EN
    if (WIDTH < 1 || DEPTH < 2) begin : g_param_check
        $error("flop_sram_1r1w_1clk: WIDTH must be >=1 and DEPTH >=2");
    end

    // Sanity checks on control inputs and enabled access addresses.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!$isunknown({WEB, REB, SD, SLP}))
                else $error("flop_sram_1r1w_1clk: X/Z on control input");
            if (WEB == 1'b0) begin
                assert (AA < DEPTH) else $error("flop_sram_1r1w_1clk: AA out of range");
            end
            if (REB == 1'b0) begin
                assert (AB < DEPTH) else $error("flop_sram_1r1w_1clk: AB out of range");
            end
        end
    end
`else
    // Checks compiled out; functional behaviour is unchanged.
`endif

endmodule

// File: tb/tb_flop_sram_1r1w_1clk.sv
// Directed bench for flop_sram_1r1w_1clk. Instance A: 8x8, mask/SD/SLP enabled.
// Instance B: 8x6, all options disabled (full-word writes, SD/SLP ignored).
module tb_flop_sram_1r1w_1clk;

    logic       clk;
    logic       rst;

    logic [2:0] a_aa, a_ab, b_aa, b_ab;
    logic [7:0] a_d, a_bweb, a_q, b_d, b_bweb, b_q;
    logic       a_web, a_reb, a_sd, a_slp;
    logic       b_web, b_reb, b_sd, b_slp;

    int total;
    int bad;

    flop_sram_1r1w_1clk #(
        .WIDTH(8), .DEPTH(8), .WITH_MASK(1), .WITH_SD(1), .WITH_SLP(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .AA(a_aa), .D(a_d), .BWEB(a_bweb), .WEB(a_web),
        .AB(a_ab), .REB(a_reb), .Q(a_q), .SD(a_sd), .SLP(a_slp)
    );

    flop_sram_1r1w_1clk #(
        .WIDTH(8), .DEPTH(6), .WITH_MASK(0), .WITH_SD(0), .WITH_SLP(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .AA(b_aa), .D(b_d), .BWEB(b_bweb), .WEB(b_web),
        .AB(b_ab), .REB(b_reb), .Q(b_q), .SD(b_sd), .SLP(b_slp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_web = 1'b1; a_reb = 1'b1; a_aa = '0; a_ab = '0; a_d = '0; a_bweb = '0;
        a_sd = 1'b0; a_slp = 1'b0;
        b_web = 1'b1; b_reb = 1'b1; b_aa = '0; b_ab = '0; b_d = '0; b_bweb = '0;
        b_sd = 1'b0; b_slp = 1'b0;
    endtask

    task automatic a_write(input logic [2:0] addr, input logic [7:0] data);
        a_web = 1'b0; a_aa = addr; a_d = data; a_bweb = 8'h00;
        tick();
        a_web = 1'b1;
    endtask

    task automatic a_read(input logic [2:0] addr);
        a_reb = 1'b0; a_ab = addr;
        tick();
        a_reb = 1'b1;
    endtask

    task automatic b_write(input logic [2:0] addr, input logic [7:0] data);
        b_web = 1'b0; b_aa = addr; b_d = data; b_bweb = 8'h00;
        tick();
        b_web = 1'b1;
    endtask

    task automatic b_read(input logic [2:0] addr);
        b_reb = 1'b0; b_ab = addr;
        tick();
        b_reb = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (a_q !== 8'h00) begin
            bad++; $display("FAIL reset_a_q got=%h exp=%h", a_q, 8'h00);
        end
        total++;
        if (b_q !== 8'h00) begin
            bad++; $display("FAIL reset_b_q got=%h exp=%h", b_q, 8'h00);
        end
        a_write(3'd1, 8'hA5);
        a_read(3'd1);
        total++;
        if (a_q !== 8'hA5) begin
            bad++; $display("FAIL reset_preload got=%h exp=%h", a_q, 8'hA5);
        end
        // Mid-cycle assert: Q must clear without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (a_q !== 8'h00) begin
            bad++; $display("FAIL reset_async_clear got=%h exp=%h", a_q, 8'h00);
        end
        // Access attempted while reset is high is aborted.
        a_web = 1'b0; a_aa = 3'd1; a_d = 8'h5A; a_reb = 1'b0; a_ab = 3'd1;
        tick();
        total++;
        if (a_q !== 8'h00) begin
            bad++; $display("FAIL reset_read_aborted got=%h exp=%h", a_q, 8'h00);
        end
        a_web = 1'b1; a_reb = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        total++;
        if (a_q !== 8'h00) begin
            bad++; $display("FAIL reset_q_stays_zero got=%h exp=%h", a_q, 8'h00);
        end
        a_read(3'd1);
        total++;
        if (a_q !== 8'hA5) begin
            bad++; $display("FAIL reset_write_aborted got=%h exp=%h", a_q, 8'hA5);
        end
    endtask

    task automatic test_write_read();
        a_write(3'd5, 8'h3C);
        a_read(3'd5);
        total++;
        if (a_q !== 8'h3C) begin
            bad++; $display("FAIL wr_rd_addr5 got=%h exp=%h", a_q, 8'h3C);
        end
        for (int i = 0; i < 3; i++) begin
            a_ab = 3'd1;  // different address, but REB high: Q must hold
            tick();
            total++;
            if (a_q !== 8'h3C) begin
                bad++; $display("FAIL wr_rd_hold cyc=%0d got=%h exp=%h", i, a_q, 8'h3C);
            end
        end
    endtask

    task automatic test_collision();
        a_write(3'd2, 8'h11);
        a_web = 1'b0; a_aa = 3'd2; a_d = 8'h22; a_bweb = 8'h00;
        a_reb = 1'b0; a_ab = 3'd2;
        tick();
        a_web = 1'b1; a_reb = 1'b1;
        total++;
        if (a_q !== 8'h11) begin
            bad++; $display("FAIL collision_old got=%h exp=%h", a_q, 8'h11);
        end
        a_read(3'd2);
        total++;
        if (a_q !== 8'h22) begin
            bad++; $display("FAIL collision_new got=%h exp=%h", a_q, 8'h22);
        end
    endtask

    task automatic test_mask();
        a_write(3'd0, 8'hFF);
        a_web = 1'b0; a_aa = 3'd0; a_d = 8'h00; a_bweb = 8'hF0;
        tick();
        a_web = 1'b1; a_bweb = 8'h00;
        a_read(3'd0);
        total++;
        if (a_q !== 8'hF0) begin
            bad++; $display("FAIL mask_on got=%h exp=%h", a_q, 8'hF0);
        end
        b_write(3'd0, 8'hFF);
        b_read(3'd0);
        total++;
        if (b_q !== 8'hFF) begin
            bad++; $display("FAIL mask_off_preload got=%h exp=%h", b_q, 8'hFF);
        end
        b_web = 1'b0; b_aa = 3'd0; b_d = 8'h00; b_bweb = 8'hF0;
        tick();
        b_web = 1'b1; b_bweb = 8'h00;
        b_read(3'd0);
        total++;
        if (b_q !== 8'h00) begin
            bad++; $display("FAIL mask_off got=%h exp=%h", b_q, 8'h00);
        end
    endtask

    task automatic test_sd_slp();
        a_write(3'd3, 8'h44);
        a_read(3'd3);
        total++;
        if (a_q !== 8'h44) begin
            bad++; $display("FAIL sdslp_preload got=%h exp=%h", a_q, 8'h44);
        end
        // Sleep: write and read attempted, both blocked, Q holds.
        a_slp = 1'b1;
        a_web = 1'b0; a_aa = 3'd3; a_d = 8'h77;
        a_reb = 1'b0; a_ab = 3'd5;
        tick();
        total++;
        if (a_q !== 8'h44) begin
            bad++; $display("FAIL slp_q_hold got=%h exp=%h", a_q, 8'h44);
        end
        // Shutdown with sleep also high: SD wins, Q cleared.
        a_sd = 1'b1;
        tick();
        total++;
        if (a_q !== 8'h00) begin
            bad++; $display("FAIL sd_priority_q_zero got=%h exp=%h", a_q, 8'h00);
        end
        a_web = 1'b1; a_reb = 1'b1;
        a_sd = 1'b0; a_slp = 1'b0;
        a_read(3'd3);
        total++;
        if (a_q !== 8'h44) begin
            bad++; $display("FAIL sdslp_retained got=%h exp=%h", a_q, 8'h44);
        end
        // SD alone on a read clears Q.
        a_sd = 1'b1; a_reb = 1'b0; a_ab = 3'd3;
        tick();
        a_sd = 1'b0; a_reb = 1'b1;
        total++;
        if (a_q !== 8'h00) begin
            bad++; $display("FAIL sd_read_zero got=%h exp=%h", a_q, 8'h00);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 6; i++) begin
            b_write(3'(i), 8'(i));
        end
        for (int i = 0; i < 6; i++) begin
            b_read(3'(i));
            total++;
            if (b_q !== 8'(i)) begin
                bad++; $display("FAIL sweep addr=%0d got=%h exp=%h", i, b_q, 8'(i));
            end
        end
        b_read(3'd7);
        total++;
        if (b_q !== 8'h00) begin
            bad++; $display("FAIL sweep_oor_read got=%h exp=%h", b_q, 8'h00);
        end
        // Out-of-range write must not alias onto any real word.
        b_write(3'd6, 8'hEE);
        b_read(3'd2);
        total++;
        if (b_q !== 8'h02) begin
            bad++; $display("FAIL sweep_oor_write got=%h exp=%h", b_q, 8'h02);
        end
        // SD/SLP are ignored when the features are disabled.
        b_sd = 1'b1; b_slp = 1'b1;
        b_write(3'd4, 8'h9C);
        b_read(3'd4);
        b_sd = 1'b0; b_slp = 1'b0;
        total++;
        if (b_q !== 8'h9C) begin
            bad++; $display("FAIL sdslp_ignored got=%h exp=%h", b_q, 8'h9C);
        end
    endtask

    task automatic test_back_to_back();
        // Write addr 4 while reading addr 5, then read addr 4 right after.
        a_web = 1'b0; a_aa = 3'd4; a_d = 8'h9A; a_bweb = 8'h00;
        a_reb = 1'b0; a_ab = 3'd5;
        tick();
        total++;
        if (a_q !== 8'h3C) begin
            bad++; $display("FAIL b2b_read5 got=%h exp=%h", a_q, 8'h3C);
        end
        a_web = 1'b1; a_ab = 3'd4;
        tick();
        total++;
        if (a_q !== 8'h9A) begin
            bad++; $display("FAIL b2b_read4 got=%h exp=%h", a_q, 8'h9A);
        end
        a_ab = 3'd2;
        tick();
        a_reb = 1'b1;
        total++;
        if (a_q !== 8'h22) begin
            bad++; $display("FAIL b2b_read2 got=%h exp=%h", a_q, 8'h22);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_collision();
        test_mask();
        test_sd_slp();
        test_sweep();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
